// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption core: one round per clock on a single 128-bit state
// register, with round keys fetched by index from an external key store.

module sub_bytes (
    input  logic [127:0] din,
    output logic [127:0] dout
);
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box = affine(a^254); a^254 is the GF(2^8) inverse and maps 0 to 0
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        logic [7:0] e;
        r = 8'h01;
        p = a;
        e = 8'hfe;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gf_mul(r, p);
            p = gf_mul(p, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
        assign dout[8*gi +: 8] = sbox(din[8*gi +: 8]);
    end
endmodule

module shift_rows (
    input  logic [127:0] din,
    output logic [127:0] dout
);
    // Byte k sits at row k%4, column k/4; row r rotates left by r columns
    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
        localparam int ROW = gi % 4;
        localparam int SRC = ROW + 4 * (((gi / 4) + ROW) % 4);
        assign dout[127-8*gi -: 8] = din[127-8*SRC -: 8];
    end
endmodule

module mix_columns (
    input  logic [127:0] din,
    output logic [127:0] dout
);
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = din[127-32*gi -: 8];
        assign a1 = din[119-32*gi -: 8];
        assign a2 = din[111-32*gi -: 8];
        assign a3 = din[103-32*gi -: 8];
        assign dout[127-32*gi -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign dout[119-32*gi -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign dout[111-32*gi -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign dout[103-32*gi -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
endmodule

module aes_round_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] din,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] dout,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

    fsm_t         fsm_reg;
    logic [3:0]   rnd_reg;
    logic [127:0] blk_reg;
    logic         out_valid_reg;
    logic         busy_reg;
    logic [127:0] sb, sr, mc;
    logic         accept;

    sub_bytes   u_sub_bytes   (.din(blk_reg), .dout(sb));
    shift_rows  u_shift_rows  (.din(sb),      .dout(sr));
    mix_columns u_mix_columns (.din(sr),      .dout(mc));

    // Gated by rst_n so the block never advertises readiness while held in reset
    assign in_ready  = rst_n & ((fsm_reg == IDLE) | ((fsm_reg == DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign rk_idx    = busy_reg ? rnd_reg : 4'd0;
    assign out_valid = out_valid_reg;
    assign dout      = blk_reg;
    assign busy      = busy_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_reg       <= IDLE;
            rnd_reg       <= 4'd0;
            blk_reg       <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else if (accept) begin
            // Covers both IDLE and the zero-bubble retire-and-accept from DONE
            blk_reg       <= din ^ rk;
            rnd_reg       <= 4'd1;
            fsm_reg       <= ROUND;
            busy_reg      <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (fsm_reg)
                IDLE: ;
                ROUND: begin
                    blk_reg <= mc ^ rk;
                    rnd_reg <= rnd_reg + 4'd1;
                    if (rnd_reg == 4'd9) fsm_reg <= FINAL;
                end
                FINAL: begin
                    blk_reg       <= sr ^ rk;
                    fsm_reg       <= DONE;
                    busy_reg      <= 1'b0;
                    out_valid_reg <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        fsm_reg       <= IDLE;
                    end
                end
                default: fsm_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state changes occur on the rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-003 SHALL have port in_valid, input, 1, a plaintext block is offered on din.
REQ-004 SHALL have port in_ready, output, 1, the block accepts din this cycle.
REQ-005 SHALL have port din, input, 128, plaintext block, byte 0 in bits [127:120], column-major byte order.
REQ-006 SHALL have port rk_idx, output, 4, round-key index requested from the external key store (0..10).
REQ-007 SHALL have port rk, input, 128, round key for rk_idx, valid combinationally in the same cycle.
REQ-008 SHALL have port out_valid, output, 1, dout holds a completed ciphertext.
REQ-009 SHALL have port out_ready, input, 1, the consumer takes dout this cycle.
REQ-010 SHALL have port dout, output, 128, ciphertext, same byte order as din.
REQ-011 SHALL have port busy, output, 1, a block is in flight (states ROUND or FINAL).

Function
REQ-012 SHALL implement iterative AES-128 encryption, one round per clock, instantiating the team's existing sub_bytes, shift_rows and mix_columns blocks on a single 128-bit state register.
REQ-013 SHALL use the FSM states IDLE, ROUND, FINAL and DONE, plus a 4-bit round counter rnd.
REQ-014 SHALL drive in_ready=1 in IDLE, and in DONE when out_ready=1; otherwise in_ready=0.
REQ-015 SHALL, on an accept (in_valid & in_ready), load state <= din ^ rk with rk_idx=0, set rnd=1, and go to ROUND.
REQ-016 SHALL, in ROUND, drive rk_idx=rnd and load state <= mix_columns(shift_rows(sub_bytes(state))) ^ rk, then increment rnd.
REQ-017 SHALL, in ROUND, go to FINAL after the edge that completes round 9, at which point rnd=10.
REQ-018 SHALL, in FINAL, drive rk_idx=10, load state <= shift_rows(sub_bytes(state)) ^ rk with no mix_columns, and go to DONE.
REQ-019 SHALL drive out_valid=1 only in DONE, with dout=state; out_valid SHALL rise exactly 10 clock edges after the accept edge.
REQ-020 SHALL, in DONE with out_ready=0, hold state, dout and out_valid stable indefinitely.
REQ-021 SHALL, in DONE with out_ready=1 and in_valid=0, go to IDLE.
REQ-022 SHALL, in DONE with out_ready=1 and in_valid=1, retire the current block and accept the new one on the same edge, going directly to ROUND with zero bubble.
REQ-023 SHALL ignore in_valid and din while busy=1, leaving state unaffected.
REQ-024 SHALL drive rk_idx=0 in IDLE and DONE so that the key store presents round key 0 for a same-cycle accept.
REQ-025 SHALL complete one block every 11 cycles under continuous in_valid and out_ready.

Reset
REQ-026 SHALL, while rst_n=0, immediately force state=IDLE, rnd=0, the state register to 0, out_valid=0, busy=0 and rk_idx=0; in_ready SHALL be 1 only after rst_n deasserts.
REQ-027 SHALL, on reset asserted mid-block, discard the in-flight block and produce no out_valid for it after release.

Verification
REQ-028 SHALL pass this directed test: FIPS-197 App. B, din=3243f6a8885a308d313198a2e0370734, rk from the key schedule of 2b7e151628aed2a6abf7158809cf4f3c -> out_valid 10 edges after accept, dout=3925841d02dc09fbdc118597196a0b32, and the state after the accept edge equals 193de3bea0f4e22b9ac68d2ae9f84808.
REQ-029 SHALL pass this directed test: the same vector with out_ready=0 for 20 cycles after out_valid -> dout and out_valid stay constant, then a single handshake occurs and the block returns to IDLE.
REQ-030 SHALL pass this directed test: back-to-back blocks with in_valid and out_ready held at 1 -> the second accept coincides with the first retire and the second out_valid arrives exactly 11 cycles after the first.
REQ-031 SHALL pass this directed test: in_valid pulsed with different data during rounds 3-7 -> in_ready=0 throughout and the ciphertext still equals 3925841d02dc09fbdc118597196a0b32.
REQ-032 SHALL pass this directed test: rst_n pulled low asynchronously at round 5 -> all outputs zero at once, and no out_valid occurs until a fresh accept.
REQ-033 SHALL pass this directed test: rk_idx is monitored over one block -> it follows the sequence 0,1,2,...,10 on consecutive cycles starting at the accept cycle.
